dm_arbiter: RTL

Two-port arbiter sharing the single data-memory port between the CPU load/store path (port 0) and a loader/debug requester (port 1). It accepts one transaction at a time, selects a winner by round-robin or fixed priority, and drives the memory with registered signals. It waits a fixed memory latency, then returns read data and a one-cycle completion pulse to the owner. It sits between `scpu`'s memory-access path and the DM storage array; the CPU uses `rdy0` to end its stall.

---
 rtl/dm_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: one transaction in flight, round-robin or fixed
// priority, registered memory strobe and a one-cycle completion pulse per port.
module dm_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter bit          RR      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [3:0]  be0,
    input  logic [3:0]  be1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rdy0,
    output logic        rdy1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        last, last_nxt;
    logic        owner, owner_nxt;
    logic        wr, wr_nxt;
    logic        win1;

    logic        gnt0_nxt, gnt1_nxt, rdy0_nxt, rdy1_nxt, busy_nxt;
    logic        mem_en_nxt, mem_we_nxt;
    logic [3:0]  mem_be_nxt;
    logic [31:0] mem_addr_nxt, mem_wdata_nxt, rdata_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            owner     <= 1'b0;
            wr        <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rdy0      <= 1'b0;
            rdy1      <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            owner     <= owner_nxt;
            wr        <= wr_nxt;
            gnt0      <= gnt0_nxt;
            gnt1      <= gnt1_nxt;
            rdy0      <= rdy0_nxt;
            rdy1      <= rdy1_nxt;
            busy      <= busy_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_be    <= mem_be_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            rdata     <= rdata_nxt;
        end
    end

    // Port 1 wins when alone, or on a round-robin tie when port 0 went last.
    always_comb begin
        win1 = req1 && (!req0 || (RR && !last));
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_nxt      = last;
        owner_nxt     = owner;
        wr_nxt        = wr;
        gnt0_nxt      = 1'b0;
        gnt1_nxt      = 1'b0;
        rdy0_nxt      = 1'b0;
        rdy1_nxt      = 1'b0;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_be_nxt    = mem_be;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        rdata_nxt     = rdata;

        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_nxt     = S_WAIT;
                    cnt_nxt       = CNT_LOAD;
                    last_nxt      = win1;
                    owner_nxt     = win1;
                    wr_nxt        = win1 ? we1 : we0;
                    gnt0_nxt      = !win1;
                    gnt1_nxt      = win1;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = win1 ? we1 : we0;
                    mem_be_nxt    = win1 ? be1 : be0;
                    mem_addr_nxt  = win1 ? addr1 : addr0;
                    mem_wdata_nxt = win1 ? wdata1 : wdata0;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                // Registered completion: the read beat lands during RESP, so the
                // capture and the rdy pulse both come from the edge leaving it.
                state_nxt = S_IDLE;
                rdy0_nxt  = !owner;
                rdy1_nxt  = owner;
                if (!wr) begin
                    rdata_nxt = mem_rdata;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state != S_IDLE) || (state_nxt != S_IDLE);
    end

endmodule
